multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style sequencing FSM that converts the single-cycle datapath into a multicycle processor sharing one unified memory for instructions and data.
- Decodes opcode/funct from the instruction register and issues per-cycle enables to the PC, IR, register file, ALU muxes and memory.
- Stalls on a memory-ready handshake.
- Sits between the instruction register and the datapath, replacing the combinational `control` block.

Parameters:
- none (encodings are fixed constants in the shared include)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  instr[31:26] from IR
- funct  in  6  instr[5:0] from IR
- mem_ready  in  1  memory completes current access this cycle
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if alu_zout (beq)
- i_or_d  out  1  0 = mem addr from PC, 1 = from ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR to register write data
- reg_dst  out  1  0 = rt, 1 = rd
- reg_write  out  1  register file write enable
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  0 = B, 1 = const 4, 2 = sext imm16, 3 = sext imm16<<2
- alu_op  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- pc_source  out  2  0 = ALU, 1 = ALUOut, 2 = jump target
- illegal  out  1  sticky unsupported-opcode flag
- state  out  4  current state (debug)

Behaviour:
- All state updates on rising clk edge. Reset is synchronous, active-high:
  - state <= S_IDLE, illegal <= 0.
  - In S_IDLE every output is 0 except state = 0.
- Reset mid-instruction aborts it; a pending memory access is dropped (mem_read/mem_write fall the next cycle).
- Outputs are decoded from state. Only pc_write, ir_write and advancement out of memory states are qualified by mem_ready.
- States and transitions:
  - S_IDLE(0) -> S_FETCH.
  - S_FETCH(1): mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=1, alu_op=add, pc_source=0.
    - ir_write and pc_write = mem_ready.
    - Stay while mem_ready=0; else -> S_DECODE.
  - S_DECODE(2): alu_src_a=0, alu_src_b=3, alu_op=add (branch target into ALUOut). Next by opcode:
    - lw 0x23 / sw 0x2B / addi 0x08 -> S_MEMADR
    - R-type 0x00 -> S_EXEC
    - beq 0x04 -> S_BRANCH
    - j 0x02 -> S_JUMP
    - other -> S_IDLE with illegal <= 1
  - S_MEMADR(3): alu_src_a=1, alu_src_b=2, alu_op=add. Next:
    - lw -> S_MEMRD
    - sw -> S_MEMWR
    - addi -> S_ADDIWB
  - S_MEMRD(4): mem_read=1, i_or_d=1. Stay until mem_ready, then -> S_MEMWB.
  - S_MEMWB(5): reg_write=1, mem_to_reg=1, reg_dst=0 -> S_FETCH.
  - S_MEMWR(6): mem_write=1, i_or_d=1. Stay until mem_ready, then -> S_FETCH.
    - mem_write stays high for the whole wait and drops the cycle after mem_ready.
  - S_EXEC(7): alu_src_a=1, alu_src_b=0, alu_op from funct:
    - 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
    - Any other funct -> alu_op=add, illegal <= 1, next S_IDLE (no writeback).
    - Valid funct -> S_ALUWB.
  - S_ALUWB(8): reg_write=1, reg_dst=1, mem_to_reg=0 -> S_FETCH.
  - S_BRANCH(9): alu_src_a=1, alu_src_b=0, alu_op=sub, pc_write_cond=1, pc_source=1 -> S_FETCH.
  - S_JUMP(10): pc_write=1, pc_source=2 -> S_FETCH.
  - S_ADDIWB(11): reg_write=1, reg_dst=0, mem_to_reg=0 -> S_FETCH.
- Unused encodings 12–15 -> S_IDLE next cycle, all outputs 0.
- illegal is cleared only by reset.
- Latencies with mem_ready tied high:
  - R-type 4 cycles; lw 5; sw 4; beq 3; j 3; addi 4.
  - Each mem_ready=0 cycle adds one cycle.
- Mutual exclusion: mem_read and mem_write are never both 1. reg_write is never 1 in a cycle with mem_read=1.

Decomposition:
- mips_defs.vh holds opcode, funct, alu_op, alu_src_b, pc_source and state localparams; shared with alu and ifu.
- One sub-module, alu_decoder: combinational funct -> {alu_op, funct_valid}. Instantiated for S_EXEC.

Test Plan:
- reset held 2 cycles, mem_ready=1 -> all outputs 0, state=0. Next cycle state=1, mem_read=1, ir_write=1, pc_write=1.
- R-type add (opcode 0x00, funct 0x20), mem_ready=1 -> states 1,2,7,8,1. alu_op=010 in state 7; reg_write=1 and reg_dst=1 in state 8 only.
- lw (0x23) with mem_ready low for 3 cycles in S_MEMRD -> mem_read=1, i_or_d=1 held 4 cycles. S_MEMWB reg_write=1, mem_to_reg=1. Total 8 cycles.
- beq (0x04) -> state 9 asserts pc_write_cond=1, alu_op=110, pc_source=1; back to state 1 after 3 cycles.
- opcode 0x3F -> after S_DECODE go to state 0, illegal=1 stays set through the next fetches. Reset clears it.
- sw (0x2B) with reset asserted while in S_MEMWR -> next cycle state=0, mem_write=0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs, ALU
// and mux selects, FSM states, and the state-to-control decode.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10,
    S_ADDIWB = 4'd11
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  // Fetch-time pc_write/ir_write depend on mem_ready and are added at the top.
  function automatic ctrl_t decode_ctrl(input state_e st, input logic [2:0] exec_op);
    ctrl_t c;
    c = '0;
    case (st)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
        c.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        c.alu_src_b = SRCB_IMM_SH;
        c.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = exec_op;
      end
      S_ALUWB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_src_b     = SRCB_B;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: begin
        c.reg_write = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// R-type funct decode: ALU operation plus a flag for supported functs.
module multicycle_control_alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [5:0] funct_i,
  output logic [2:0] alu_op_o,
  output logic       funct_valid_o
);

  // Unsupported functs fall back to add so the ALU mux stays defined.
  always_comb begin
    alu_op_o      = ALU_ADD;
    funct_valid_o = 1'b1;
    case (funct_i)
      FN_ADD:  alu_op_o = ALU_ADD;
      FN_SUB:  alu_op_o = ALU_SUB;
      FN_AND:  alu_op_o = ALU_AND;
      FN_OR:   alu_op_o = ALU_OR;
      FN_SLT:  alu_op_o = ALU_SLT;
      default: begin
        alu_op_o      = ALU_ADD;
        funct_valid_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencing FSM for a multicycle MIPS with a unified instruction/data
// memory; control outputs are registered alongside the state.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  ctrl_t      ctrl_q;
  logic [2:0] exec_op_s;
  logic       funct_valid_s;
  logic       fetch_done_s;

  multicycle_control_alu_decoder u_alu_decoder (
    .funct_i       (funct),
    .alu_op_o      (exec_op_s),
    .funct_valid_o (funct_valid_s)
  );

  // Next-state selection and sticky illegal detection.
  always_comb begin
    state_d   = S_IDLE;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW, OP_ADDI: state_d = S_MEMADR;
          OP_RTYPE:              state_d = S_EXEC;
          OP_BEQ:                state_d = S_BRANCH;
          OP_J:                  state_d = S_JUMP;
          default: begin
            state_d   = S_IDLE;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        case (opcode)
          OP_LW:   state_d = S_MEMRD;
          OP_SW:   state_d = S_MEMWR;
          OP_ADDI: state_d = S_ADDIWB;
          default: state_d = S_IDLE;
        endcase
      end
      S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
      S_EXEC: begin
        if (funct_valid_s) begin
          state_d = S_ALUWB;
        end else begin
          state_d   = S_IDLE;
          illegal_d = 1'b1;
        end
      end
      S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, sticky flag and control decode of the upcoming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      illegal_q <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      ctrl_q    <= decode_ctrl(state_d, exec_op_s);
    end
  end

  assign fetch_done_s  = (state_q == S_FETCH) && mem_ready;
  assign pc_write      = ctrl_q.pc_write | fetch_done_s;
  assign ir_write      = fetch_done_s;
  assign pc_write_cond = ctrl_q.pc_write_cond;
  assign i_or_d        = ctrl_q.i_or_d;
  assign mem_read      = ctrl_q.mem_read;
  assign mem_write     = ctrl_q.mem_write;
  assign mem_to_reg    = ctrl_q.mem_to_reg;
  assign reg_dst       = ctrl_q.reg_dst;
  assign reg_write     = ctrl_q.reg_write;
  assign alu_src_a     = ctrl_q.alu_src_a;
  assign alu_src_b     = ctrl_q.alu_src_b;
  assign alu_op        = ctrl_q.alu_op;
  assign pc_source     = ctrl_q.pc_source;
  assign illegal       = illegal_q;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: per-instruction expected state sequences and a
// table-driven output model, with directed and randomized instruction streams.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state;

  int  tests_run    = 0;
  int  tests_failed = 0;
  bit  ill_model    = 1'b0;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal(illegal), .state(state)
  );

  function automatic logic [2:0] fn_op(input logic [5:0] fn);
    case (fn)
      6'h20: return 3'b010;
      6'h22: return 3'b110;
      6'h24: return 3'b000;
      6'h25: return 3'b001;
      6'h2A: return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic bit fn_ok(input logic [5:0] fn);
    return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h25) || (fn == 6'h2A);
  endfunction

  // Output table: {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
  // mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source}
  function automatic logic [16:0] model_outs(input int st, input logic mr, input logic [5:0] fn);
    logic pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, sa;
    logic [1:0] sb, ps;
    logic [2:0] ao;
    {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, sa} = 10'd0;
    sb = 2'd0; ps = 2'd0; ao = 3'd0;
    case (st)
      1:  begin mrd = 1'b1; sb = 2'd1; ao = 3'b010; irw = mr; pw = mr; end
      2:  begin sb = 2'd3; ao = 3'b010; end
      3:  begin sa = 1'b1; sb = 2'd2; ao = 3'b010; end
      4:  begin mrd = 1'b1; iod = 1'b1; end
      5:  begin rw = 1'b1; m2r = 1'b1; end
      6:  begin mwr = 1'b1; iod = 1'b1; end
      7:  begin sa = 1'b1; ao = fn_op(fn); end
      8:  begin rw = 1'b1; rd = 1'b1; end
      9:  begin sa = 1'b1; ao = 3'b110; pwc = 1'b1; ps = 2'd1; end
      10: begin pw = 1'b1; ps = 2'd2; end
      11: begin rw = 1'b1; end
      default: ;
    endcase
    return {pw, pwc, iod, mrd, mwr, irw, m2r, rd, rw, sa, sb, ao, ps};
  endfunction

  // Runs one instruction starting in the fetch state; stall < 0 means random.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int fetch_stall, input int mem_stall, output int ncyc);
    int ph[$];
    logic [16:0] exp_o, obs_o;
    logic mr;
    int stalls;
    opcode = op;
    funct  = fn;
    ncyc   = 0;
    case (op)
      6'h00: begin ph = '{1, 2, 7}; ph.push_back(fn_ok(fn) ? 8 : 0); end
      6'h23: ph = '{1, 2, 3, 4, 5};
      6'h2B: ph = '{1, 2, 3, 6};
      6'h04: ph = '{1, 2, 9};
      6'h02: ph = '{1, 2, 10};
      6'h08: ph = '{1, 2, 3, 11};
      default: ph = '{1, 2, 0};
    endcase
    for (int i = 0; i < ph.size(); i++) begin
      if (ph[i] == 1)
        stalls = (fetch_stall < 0) ? int'($urandom_range(0, 3)) : fetch_stall;
      else if (ph[i] == 4 || ph[i] == 6)
        stalls = (mem_stall < 0) ? int'($urandom_range(0, 3)) : mem_stall;
      else
        stalls = 0;
      for (int k = 0; k <= stalls; k++) begin
        if (ph[i] == 1 || ph[i] == 4 || ph[i] == 6) mr = (k == stalls);
        else mr = 1'($urandom_range(0, 1));
        @(negedge clk);
        mem_ready = mr;
        #1;
        if (ph[i] != 0) ncyc++;
        exp_o = model_outs(ph[i], mr, fn);
        obs_o = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};
        tests_run++;
        if (state !== 4'(ph[i])) begin
          tests_failed++;
          $display("FAIL state op=%h got %0d exp %0d", op, state, ph[i]);
        end
        tests_run++;
        if (obs_o !== exp_o) begin
          tests_failed++;
          $display("FAIL outputs op=%h st=%0d got %h exp %h", op, ph[i], obs_o, exp_o);
        end
        tests_run++;
        if (illegal !== ill_model) begin
          tests_failed++;
          $display("FAIL illegal op=%h st=%0d got %b exp %b", op, ph[i], illegal, ill_model);
        end
        tests_run++;
        if ((mem_read && mem_write) || (reg_write && mem_read)) begin
          tests_failed++;
          $display("FAIL exclusion st=%0d got rd=%b wr=%b rw=%b exp no overlap",
                   ph[i], mem_read, mem_write, reg_write);
        end
      end
      if (i + 1 < ph.size() && ph[i + 1] == 0) ill_model = 1'b1;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    tests_run++;
    if (state !== 4'd0 || illegal !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_apply got st=%0d ill=%b rd=%b wr=%b exp 0 0 0 0",
               state, illegal, mem_read, mem_write);
    end
    reset = 1'b0;
    ill_model = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1; mem_ready = 1'b1; opcode = 6'h02; funct = 6'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    tests_run++;
    if (state !== 4'd0 || illegal !== 1'b0 ||
        {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
         reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source} !== 17'd0) begin
      tests_failed++;
      $display("FAIL reset_state got st=%0d ill=%b rd=%b exp all zero", state, illegal, mem_read);
    end
    reset = 1'b0;
    run_instr(6'h02, 6'h00, 0, 0, n);
    tests_run++;
    if (n !== 3) begin
      tests_failed++;
      $display("FAIL j_latency got %0d exp 3", n);
    end
  endtask

  task automatic test_rtype_add();
    int n;
    run_instr(6'h00, 6'h20, 0, 0, n);
    tests_run++;
    if (n !== 4) begin
      tests_failed++;
      $display("FAIL rtype_latency got %0d exp 4", n);
    end
  endtask

  task automatic test_lw_stall();
    int n;
    run_instr(6'h23, 6'h11, 0, 3, n);
    tests_run++;
    if (n !== 8) begin
      tests_failed++;
      $display("FAIL lw_latency got %0d exp 8", n);
    end
  endtask

  task automatic test_beq();
    int n;
    run_instr(6'h04, 6'h00, 0, 0, n);
    tests_run++;
    if (n !== 3) begin
      tests_failed++;
      $display("FAIL beq_latency got %0d exp 3", n);
    end
  endtask

  task automatic test_illegal();
    int n;
    run_instr(6'h3F, 6'h20, 0, 0, n);
    run_instr(6'h00, 6'h20, 1, 0, n);
    run_instr(6'h00, 6'h3E, 0, 0, n);
    apply_reset();
  endtask

  task automatic test_sw_reset();
    int n;
    opcode = 6'h2B; funct = 6'h00;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      mem_ready = (c == 0);
      #1;
      tests_run++;
      if (state !== 4'(c < 3 ? c + 1 : 6)) begin
        tests_failed++;
        $display("FAIL sw_seq got %0d exp %0d", state, (c < 3 ? c + 1 : 6));
      end
    end
    tests_run++;
    if (mem_write !== 1'b1 || i_or_d !== 1'b1) begin
      tests_failed++;
      $display("FAIL sw_memwr got wr=%b iod=%b exp 1 1", mem_write, i_or_d);
    end
    reset = 1'b1;
    @(negedge clk);
    #1;
    tests_run++;
    if (state !== 4'd0 || mem_write !== 1'b0 || mem_read !== 1'b0) begin
      tests_failed++;
      $display("FAIL sw_reset got st=%0d wr=%b rd=%b exp 0 0 0", state, mem_write, mem_read);
    end
    reset = 1'b0;
    ill_model = 1'b0;
    run_instr(6'h2B, 6'h00, 0, 2, n);
    tests_run++;
    if (n !== 6) begin
      tests_failed++;
      $display("FAIL sw_latency got %0d exp 6", n);
    end
  endtask

  task automatic test_random();
    logic [5:0] op, fn;
    logic [5:0] ops [6];
    logic [5:0] fns [5];
    int n;
    ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    for (int t = 0; t < 60; t++) begin
      int kind;
      kind = int'($urandom_range(0, 7));
      fn = fns[$urandom_range(0, 4)];
      if (kind < 6) op = ops[kind];
      else begin
        op = 6'($urandom);
        while (op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
               op == 6'h02 || op == 6'h08) op = 6'($urandom);
      end
      if (kind == 7) begin op = 6'h00; fn = 6'($urandom); end
      run_instr(op, fn, -1, -1, n);
      if (t == 30) apply_reset();
    end
  endtask

  initial begin
    reset = 1'b1; mem_ready = 1'b0; opcode = 6'h00; funct = 6'h00;
    test_reset();
    test_rtype_add();
    test_lw_stall();
    test_beq();
    test_illegal();
    test_sw_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
